// File: rtl/axi4lite_regfile.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_regfile
// Description : AXI4-Lite slave register file with independent AW/W holding
//               registers, byte strobes and registered, held B/R responses.
//               Optional macro AXIL_REGFILE_SLVERR_EN: SLVERR on out-of-range.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4lite_regfile #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int c_STRB_W   = DATA_WIDTH / 8;
    localparam int c_OFF_BITS = $clog2(c_STRB_W);
    localparam int c_IDX_W    = ADDR_WIDTH - c_OFF_BITS;
    localparam logic [1:0] c_RESP_OKAY = 2'b00;
`ifdef AXIL_REGFILE_SLVERR_EN
    localparam logic [1:0] c_RESP_OOR  = 2'b10;
`else
    localparam logic [1:0] c_RESP_OOR  = 2'b00;
`endif

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic                    r_aw_held;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic                    r_w_held;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [c_STRB_W-1:0]     r_wstrb;
    logic                    r_bvalid;
    logic [1:0]              r_bresp;
    logic                    r_rvalid;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [1:0]              r_rresp;

    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_ar_hs;
    logic                    w_commit;
    logic [ADDR_WIDTH-1:0]   w_wr_addr;
    logic [DATA_WIDTH-1:0]   w_wr_data;
    logic [c_STRB_W-1:0]     w_wr_strb;
    logic [c_IDX_W-1:0]      w_wr_idx;
    logic [c_IDX_W-1:0]      w_rd_idx;
    logic                    w_wr_in_range;
    logic                    w_rd_in_range;
    logic [DATA_WIDTH-1:0]   w_rd_data;
    logic                    w_unused;

    // READY outputs are gated by reset directly since reset is asynchronous
    assign AWREADY = ~ARESET & ~r_aw_held & ~r_bvalid;
    assign WREADY  = ~ARESET & ~r_w_held  & ~r_bvalid;
    assign ARREADY = ~ARESET & ~r_rvalid;

    assign w_aw_hs = AWVALID & AWREADY;
    assign w_w_hs  = WVALID  & WREADY;
    assign w_ar_hs = ARVALID & ARREADY;

    // Address and data may each come from the holding register or the live bus
    assign w_wr_addr = r_aw_held ? r_awaddr : AWADDR;
    assign w_wr_data = r_w_held  ? r_wdata  : WDATA;
    assign w_wr_strb = r_w_held  ? r_wstrb  : WSTRB;
    assign w_commit  = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);

    assign w_wr_idx      = w_wr_addr[ADDR_WIDTH-1:c_OFF_BITS];
    assign w_rd_idx      = ARADDR[ADDR_WIDTH-1:c_OFF_BITS];
    assign w_wr_in_range = 32'(w_wr_idx) < 32'(NUM_REGS);
    assign w_rd_in_range = 32'(w_rd_idx) < 32'(NUM_REGS);

    assign w_unused = ^{w_wr_addr[c_OFF_BITS-1:0], ARADDR[c_OFF_BITS-1:0]};

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_rd_idx == c_IDX_W'(i)) begin
                w_rd_data = r_regs[i];
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_idx == c_IDX_W'(i)) begin
                    for (int b = 0; b < c_STRB_W; b++) begin
                        if (w_wr_strb[b]) begin
                            r_regs[i][8*b +: 8] <= w_wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_aw_held <= 1'b0;
            r_awaddr  <= '0;
            r_w_held  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
        end else if (w_commit) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_wr_in_range ? c_RESP_OKAY : c_RESP_OOR;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= AWADDR;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= WDATA;
                r_wstrb  <= WSTRB;
            end
            if (r_bvalid && BREADY) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Read data is captured before any same-edge write lands in r_regs
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= 2'b00;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_in_range ? c_RESP_OKAY : c_RESP_OOR;
        end else if (r_rvalid && RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    assign BVALID = r_bvalid;
    assign BRESP  = r_bresp;
    assign RVALID = r_rvalid;
    assign RDATA  = r_rdata;
    assign RRESP  = r_rresp;

endmodule
`default_nettype wire
